// File: rtl/mdu_if.sv
// -----------------------------------------------------------------------------
// mdu_if : request/response bundle between the execute stage and the
// multi-cycle multiply/divide unit.
//
//   start   master->slave  operation request, sampled only while the unit is idle
//   funct3  master->slave  RV32M operation select (MUL..REMU)
//   op_a    master->slave  rs1 operand
//   op_b    master->slave  rs2 operand
//   result  slave->master  result, valid with done, held until the next accepted start
//   busy    slave->master  unit working; the core stalls while high
//   done    slave->master  single-cycle completion pulse
//   ZR      slave->master  result == 0, valid with result
// -----------------------------------------------------------------------------
interface mdu_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            done;
  logic            ZR;

  modport master (
    output start, funct3, op_a, op_b,
    input  result, busy, done, ZR
  );

  modport slave (
    input  start, funct3, op_a, op_b,
    output result, busy, done, ZR
  );
endinterface

// File: rtl/mdu_iterative.sv
// -----------------------------------------------------------------------------
// mdu_iterative : multi-cycle RV32M multiply/divide unit.
//
// One operation per start pulse. Operands are converted to magnitudes on
// entry, the magnitude product / quotient+remainder is built one bit per cycle
// in a 2*XLEN accumulator (shift-add multiply, restoring divide), and the sign
// is applied in the FINISH cycle before the result is registered.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset; aborts any operation in flight
//   bus    slave modport of mdu_if (start/funct3/op_a/op_b in,
//          result/busy/done/ZR out)
//
// Configuration macro
//   FAST_MUL_EN  when defined, multiplies use a single-cycle 2*XLEN multiplier
//                (IDLE -> FINISH, done two cycles after start); divides stay
//                iterative. When undefined no hardware multiplier is built.
// -----------------------------------------------------------------------------
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst_n,
  mdu_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;      // mul: {partial sum, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
  logic [2:0]        op;
  logic              sign_a;   // captured operand signs (0 for unsigned operands)
  logic              sign_b;
  logic              special;  // acc low half already holds the final result
  logic [XLEN-1:0]   result_q;
  logic              busy_q;
  logic              done_q;
  logic              zr_q;

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ZR     = zr_q;

  // ---------------------------------------------------------------- request decode
  logic            is_div, a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b, spec_val;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    is_div   = bus.funct3[2];
    a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) || (is_div && !bus.funct3[0]);
    b_signed = (bus.funct3 == 3'b001) || (is_div && !bus.funct3[0]);
    neg_a    = a_signed && bus.op_a[XLEN-1];
    neg_b    = b_signed && bus.op_b[XLEN-1];
    abs_a    = neg_a ? -bus.op_a : bus.op_a;
    abs_b    = neg_b ? -bus.op_b : bus.op_b;
    div_zero = is_div && (bus.op_b == '0);
    div_ovf  = is_div && !bus.funct3[0] && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
    // Divide by zero: quotient all ones, remainder = dividend.
    // Signed overflow: quotient = MIN_NEG, remainder = 0.
    spec_val = '0;
    if (div_zero) spec_val = bus.funct3[1] ? bus.op_a : '1;
    else          spec_val = bus.funct3[1] ? '0 : MIN_NEG;
  end

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif

  // ---------------------------------------------------------------- one iteration
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_ext;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] iter_next;

  always_comb begin
    // Shift-add: add the multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right, keeping the carry.
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd & {XLEN{acc[0]}}};
    // Restoring divide: shift left one bit; subtract the divisor when it fits.
    rem_ext  = acc[2*XLEN-1:XLEN-1];
    div_diff = rem_ext - {1'b0, opnd};
    if (!op[2])                     iter_next = {mul_sum, acc[XLEN-1:1]};
    else if (rem_ext >= {1'b0, opnd}) iter_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else                            iter_next = {rem_ext[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  // ---------------------------------------------------------------- sign fix / select
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin;

  always_comb begin
    prod = (sign_a ^ sign_b) ? -acc : acc;
    quo  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];  // remainder follows dividend
    fin  = '0;
    case (op)
      3'b000:                 fin = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin = quo;
      default:                fin = rem;
    endcase
    if (special) fin = acc[XLEN-1:0];
  end

  // ---------------------------------------------------------------- control FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      op       <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      special  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zr_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op     <= bus.funct3;
            sign_a <= neg_a;
            sign_b <= neg_b;
            count  <= '0;
            busy_q <= 1'b1;
            if (div_zero || div_ovf) begin
              special <= 1'b1;
              acc     <= {{XLEN{1'b0}}, spec_val};
              state   <= FINISH;
            end else begin
              special <= 1'b0;
              if (is_div) begin
                acc   <= {{XLEN{1'b0}}, abs_a};
                opnd  <= abs_b;
                state <= CALC;
              end else begin
`ifdef FAST_MUL_EN
                acc   <= fast_prod;
                state <= FINISH;
`else
                acc   <= {{XLEN{1'b0}}, abs_b};
                opnd  <= abs_a;
                state <= CALC;
`endif
              end
            end
          end
        end
        CALC: begin
          acc   <= iter_next;
          count <= count + CW'(1);
          if (count == CW'(XLEN-1)) state <= FINISH;
        end
        FINISH: begin
          result_q <= fin;
          zr_q     <= (fin == '0);
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// -----------------------------------------------------------------------------
// tb_mdu_iterative : self-checking bench for mdu_iterative (XLEN = 32).
// A reference model computes each result with 64-bit integer arithmetic and
// tracks when done/busy must appear; a compare process checks the DUT against
// it on every falling edge. Directed cases pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_mdu_iterative;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_if #(.XLEN(32)) bus ();

  mdu_iterative #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  function automatic logic [31:0] ref_fn(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'h0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Cycles from the start-sampling edge to the cycle in which done is high.
  function automatic int lat_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'h0)) return 2;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef FAST_MUL_EN
    if (!f[2]) return 2;
`endif
    return 34;
  endfunction

  int          m_left = 0;     // edges remaining until done
  bit          m_done = 1'b0;
  bit          m_zr   = 1'b1;
  logic [31:0] m_res  = '0;
  logic [31:0] p_res  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = '0;
      m_zr   = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_res  = p_res;
          m_zr   = (p_res == 32'h0);
        end
      end else if (bus.start) begin
        p_res  = ref_fn(bus.funct3, bus.op_a, bus.op_b);
        m_left = lat_fn(bus.funct3, bus.op_a, bus.op_b) - 1;
      end
    end
  end

  // ---------------------------------------------------------------- compare process
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(bus.busy), 32'(m_left > 0));
      check("done", 32'(bus.done), 32'(m_done));
      if (m_done || m_left == 0) begin
        check("result", bus.result, m_res);
        check("zr", 32'(bus.ZR), 32'(m_zr));
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic wait_idle();
    for (int i = 0; i < 100 && m_left != 0; i++) @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    wait_idle();
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    @(negedge clk);
    bus.start  = 1'b0;
    // Scramble the inputs: the unit must work from its captured copies.
    bus.funct3 = 3'($urandom);
    bus.op_a   = $urandom;
    bus.op_b   = $urandom;
    lat = 1;
    while (!bus.done && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) begin
      n_vec++;
      n_miss++;
      $display("FAIL timeout: no done within %0d cycles, expected %0d", lat, lat_fn(f, a, b));
    end
  endtask

  task automatic directed(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    run_op(f, a, b, lat);
    check({name, "_res"}, bus.result, exp);
    check({name, "_zr"}, 32'(bus.ZR), 32'(exp == 32'h0));
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_model"}, ref_fn(f, a, b), exp);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  initial begin
    int          lat;
    int          dones;
    logic [31:0] done_res;
    logic [2:0]  f;
    logic [31:0] a, b;

    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;

    // Reset state
    #12;
    check("rst_result", bus.result, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_zr", 32'(bus.ZR), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply
    directed("mul_7x6", 3'b000, 32'd7, 32'd6, 32'd42, MUL_LAT);
    directed("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, MUL_LAT);
    directed("mulhu_m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    directed("mulhsu_m1x2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);

    // Divide
    directed("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    directed("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    directed("divu_2565", 3'b101, 32'd2565, 32'd1560, 32'd1, 34);
    directed("remu_2565", 3'b111, 32'd2565, 32'd1560, 32'd1005, 34);

    // Special cases
    directed("divu_by0", 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 2);
    directed("remu_by0", 3'b111, 32'd100, 32'd0, 32'd100, 2);
    directed("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    directed("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);

    // Start pulsed mid-DIV is ignored; exactly one done with the original result
    wait_idle();
    bus.start  = 1'b1;
    bus.funct3 = 3'b100;
    bus.op_a   = 32'hFFFF_FFF9;
    bus.op_b   = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd5;
    bus.op_b   = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    dones     = 0;
    done_res  = '0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        done_res = bus.result;
      end
    end
    check("busy_start_dones", 32'(dones), 32'd1);
    check("busy_start_res", done_res, 32'hFFFF_FFFD);

    // Reset mid-MUL aborts immediately
    wait_idle();
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd7;
    bus.op_b   = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_done", 32'(bus.done), 32'h0);
    check("abort_result", bus.result, 32'h0);
    check("abort_zr", 32'(bus.ZR), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    directed("mul_after_rst", 3'b000, 32'd123, 32'd456, 32'd56088, MUL_LAT);

    // Randomized operations, back to back
    for (int i = 0; i < 300; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op(f, a, b, lat);
      check("rand_lat", 32'(lat), 32'(lat_fn(f, a, b)));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
